// File: rtl/fifo_word_packer.sv
// Byte FIFO read-side consumer: pops bytes and packs BYTES of them into one little-endian word.
// A partial word is flushed once the FIFO has stayed empty for TIMEOUT cycles.
module fifo_word_packer #(
  parameter int DATA_W  = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    RReq,
  input  logic [DATA_W-1:0]       RData,
  input  logic                    EMP,
  output logic [DATA_W*BYTES-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_bytes,
  output logic [15:0]             word_count
);

  localparam int             TW   = $clog2(TIMEOUT + 1);
  localparam logic [3:0]     NB   = 4'(BYTES);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT);
  localparam logic [TW-1:0]  TPRE = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FILL, FULLW, FLUSH} state_t;

  state_t                  state, state_n;
  logic [DATA_W*BYTES-1:0] asm_q, asm_n;
  logic [3:0]              issued, issued_n;
  logic [3:0]              captured, cap_n, captured_n;
  logic                    inflight;
  logic [TW-1:0]           tmo, tmo_n;
  logic                    free, count_en, tmo_hit, full_xfer, flush_xfer, xfer;

  assign RReq = reset && !EMP && (issued < NB);

  always_comb begin
    free  = !out_valid || out_ready;
    cap_n = captured + {3'b000, inflight};
    asm_n = asm_q;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (inflight && captured == 4'(i)) asm_n[i*DATA_W +: DATA_W] = RData;
    end

    // Flush fires on the edge that would bring tmo to TIMEOUT; a byte landing that edge wins.
    count_en   = EMP && !inflight && (captured != '0) && (state == FILL || state == FLUSH);
    tmo_hit    = count_en && (tmo >= TPRE);
    full_xfer  = (cap_n == NB) && free;
    flush_xfer = tmo_hit && free;
    xfer       = full_xfer || flush_xfer;

    issued_n   = xfer ? '0 : issued + {3'b000, RReq};
    captured_n = xfer ? '0 : cap_n;

    tmo_n = '0;
    if (count_en && !xfer) tmo_n = tmo_hit ? TMAX : tmo + TW'(1);

    if (cap_n == NB && !free)   state_n = FULLW;
    else if (tmo_hit && !free)  state_n = FLUSH;
    else if (issued_n != '0)    state_n = FILL;
    else                        state_n = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      asm_q      <= '0;
      issued     <= '0;
      captured   <= '0;
      inflight   <= 1'b0;
      tmo        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_bytes  <= '0;
      word_count <= '0;
    end else begin
      state    <= state_n;
      asm_q    <= xfer ? '0 : asm_n;
      issued   <= issued_n;
      captured <= captured_n;
      inflight <= RReq;
      tmo      <= tmo_n;
      if (xfer) begin
        out_data  <= asm_n;
        out_bytes <= cap_n;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready) word_count <= word_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a byte-stream reference model and literal word checks.
module tb_fifo_word_packer;
  localparam int DATA_W  = 8;
  localparam int BYTES   = 4;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rreq;
  logic [7:0]  rdata = '0;
  logic        emp;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_bytes;
  logic [15:0] word_count;

  fifo_word_packer #(.DATA_W(DATA_W), .BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .RReq(rreq), .RData(rdata), .EMP(emp),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bytes(out_bytes), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  nb;
  } word_t;

  // FIFO feeding the DUT: data valid the cycle after an accepted pop.
  logic [7:0] fifo[$];
  int         wr_cnt = 0;
  int         rd_cnt = 0;
  logic [7:0] b_pop;
  assign emp = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (rreq && fifo.size() > 0) begin
      b_pop = fifo.pop_front();
      rdata  <= b_pop;
      rd_cnt <= rd_cnt + 1;
    end
  end

  // Model: bytes are consumed in order, grouped BYTES at a time, or cut short by a flush.
  logic [7:0]  pend[$];
  word_t       expq[$];
  word_t       got[$];
  logic [15:0] model_wc = '0;

  function automatic word_t pack_pend();
    word_t w;
    w.data = '0;
    w.nb   = 4'(pend.size());
    for (int i = 0; i < pend.size(); i++) w.data[i*8 +: 8] = pend[i];
    return w;
  endfunction

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    wr_cnt++;
    pend.push_back(b);
    if (pend.size() == BYTES) begin
      expq.push_back(pack_pend());
      pend.delete();
    end
  endtask

  task automatic model_flush();
    if (pend.size() > 0) begin
      expq.push_back(pack_pend());
      pend.delete();
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      #3;
      if (expq.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after %0d cycles, %0d words outstanding", name, budget, expq.size());
    end
  endtask

  // Per-cycle compare, sampled just before the rising edge the handshake happens on.
  initial begin
    logic        hold;
    logic [31:0] hd;
    logic [3:0]  hb;
    word_t       e, w;
    hold = 1'b0;
    hd   = '0;
    hb   = '0;
    forever begin
      @(negedge clk);
      #2;
      chk("word_count", 64'(word_count), 64'(model_wc));
      if (emp) chk("rreq_when_empty", 64'(rreq), 64'd0);
      if (out_valid && hold) begin
        chk("hold_data", 64'(out_data), 64'(hd));
        chk("hold_bytes", 64'(out_bytes), 64'(hb));
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h/%0d, want no word", out_data, out_bytes);
        end else begin
          e = expq.pop_front();
          chk("word_data", 64'(out_data), 64'(e.data));
          chk("word_bytes", 64'(out_bytes), 64'(e.nb));
        end
        w.data = out_data;
        w.nb   = out_bytes;
        got.push_back(w);
        model_wc++;
      end
      hold = out_valid && !out_ready;
      hd   = out_data;
      hb   = out_bytes;
    end
  end

  initial begin
    int rise;
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_rreq", 64'(rreq), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_bytes", 64'(out_bytes), 64'd0);
    chk("rst_wc", 64'(word_count), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Empty FIFO with nothing captured: no word, no pops.
    repeat (20) @(negedge clk);
    #3;
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_rreq", 64'(rreq), 64'd0);

    // 1: two full words back to back
    @(negedge clk);
    got.delete();
    for (int i = 1; i <= 8; i++) push(8'(2 * i));
    wait_idle(60, "t1_idle");
    chk("t1_nwords", 64'(got.size()), 64'd2);
    if (got.size() >= 2) begin
      chk("t1_w0", 64'(got[0].data), 64'h0806_0402);
      chk("t1_w0_bytes", 64'(got[0].nb), 64'd4);
      chk("t1_w1", 64'(got[1].data), 64'h100E_0C0A);
    end
    chk("t1_wc", 64'(word_count), 64'd2);

    // 2: three bytes then empty -> partial flush after TIMEOUT empty cycles
    @(negedge clk);
    got.delete();
    push(8'd2); push(8'd4); push(8'd6);
    model_flush();
    rise = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        rise = i;
        break;
      end
    end
    checks++;
    if (rise < 20 || rise > 21) begin
      errors++;
      $display("FAIL t2_flush_edge: got edge %0d, want 20..21", rise);
    end
    wait_idle(60, "t2_idle");
    repeat (30) @(negedge clk);
    #3;
    chk("t2_no_more_valid", 64'(out_valid), 64'd0);
    chk("t2_nwords", 64'(got.size()), 64'd1);
    if (got.size() >= 1) begin
      chk("t2_w0", 64'(got[0].data), 64'h0006_0402);
      chk("t2_w0_bytes", 64'(got[0].nb), 64'd3);
    end

    // 3: fourth byte arrives late in the timeout window -> full word, no flush
    @(negedge clk);
    got.delete();
    push(8'd2); push(8'd4); push(8'd6);
    repeat (18) @(posedge clk);
    @(negedge clk);
    push(8'd8);
    wait_idle(60, "t3_idle");
    chk("t3_nwords", 64'(got.size()), 64'd1);
    if (got.size() >= 1) begin
      chk("t3_w0", 64'(got[0].data), 64'h0806_0402);
      chk("t3_w0_bytes", 64'(got[0].nb), 64'd4);
    end

    // 4: back-pressure; one word held, one assembled, then pops stall
    @(negedge clk);
    got.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(8'h11 + i));
    repeat (20) @(negedge clk);
    #3;
    chk("t4_rreq_stalled", 64'(rreq), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_held", 64'(out_data), 64'h1413_1211);
    chk("t4_fifo_left", 64'(wr_cnt - rd_cnt), 64'd4);
    @(negedge clk);
    out_ready = 1'b1;
    wait_idle(60, "t4_idle");
    chk("t4_nwords", 64'(got.size()), 64'd3);
    if (got.size() >= 3) begin
      chk("t4_w0", 64'(got[0].data), 64'h1413_1211);
      chk("t4_w1", 64'(got[1].data), 64'h1817_1615);
      chk("t4_w2", 64'(got[2].data), 64'h1C1B_1A19);
    end

    // 5: asynchronous reset mid-word
    @(negedge clk);
    got.delete();
    push(8'h21); push(8'h22);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    reset = 1'b0;
    pend.delete();
    model_wc = '0;
    #1;
    chk("t5_rreq", 64'(rreq), 64'd0);
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_bytes", 64'(out_bytes), 64'd0);
    chk("t5_wc", 64'(word_count), 64'd0);
    @(negedge clk);
    #3;
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(8'(8'h31 + i));
    wait_idle(60, "t5_idle");
    chk("t5_nwords", 64'(got.size()), 64'd1);
    if (got.size() >= 1) begin
      chk("t5_w0", 64'(got[0].data), 64'h3433_3231);
      chk("t5_w0_bytes", 64'(got[0].nb), 64'd4);
    end

    // 6: word_count wrap from 0xFFFF
    @(negedge clk);
    #3;
    force dut.word_count = 16'hFFFF;
    model_wc = 16'hFFFF;
    #1;
    release dut.word_count;
    @(negedge clk);
    got.delete();
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i));
    wait_idle(60, "t6_idle");
    chk("t6_wc_wrap", 64'(word_count), 64'd0);
    chk("t6_nwords", 64'(got.size()), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
